ahb_decoder_stage_param: RTL

Parametrised AHB slave-side decoder stage for the bus matrix. It maps each input-stage address onto one of NUM_PORTS output stages, or onto an integrated default slave, and steers the data-phase HREADYOUT, HRESP and HRDATA back from whichever port owns the data phase. Over the fixed 4-port decoder it adds parametrised port count and regions, run-time port disable, a two-cycle ERROR default slave, and error capture/count status. It sits between one input stage and the output stages, one instance per matrix slave interface.

---
 rtl/ahb_decoder_pkg.sv | 21 ++
 rtl/ahb_decoder_stage_param_err.sv | 98 +++++++++
 rtl/ahb_decoder_stage_param.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ahb_decoder_pkg.sv
// Shared encodings and types for the AHB decoder stage and its default slave.
package ahb_decoder_pkg;

  // Width of the decoded address slice HADDR[31:10].
  localparam int ADDR_W = 22;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahb_decoder_stage_param_err.sv
// Default slave for unmapped or disabled regions.
// NONSEQ/SEQ transfers get a two-cycle ERROR response.
// Each error start records the faulting address and bumps a saturating counter.
module ahb_default_slave_err
  import ahb_decoder_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HREADYS,
  input  logic                 dft_sel,
  input  logic                 xfer_active,
  input  logic [ADDR_W-1:0]    decode_addr_dec,
  input  logic                 err_clr,
  output logic                 dft_ready,
  output logic [1:0]           dft_resp,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    err_addr
);

  ds_state_e              state_q, state_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic [ADDR_W-1:0]      err_addr_q, err_addr_d;
  logic                   accept;
  logic                   err_start;

  // Counter stops at all-ones rather than wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (v == {ERR_CNT_W{1'b1}}) begin
      return v;
    end
    return v + ERR_CNT_W'(1);
  endfunction

  assign accept = dft_sel & HREADYS & xfer_active;

  // Next-state and response outputs; ERR1 always advances, other states wait on HREADYS.
  always_comb begin
    state_d   = state_q;
    err_start = 1'b0;
    dft_ready = 1'b1;
    dft_resp  = HRESP_OKAY;
    case (state_q)
      DS_IDLE: begin
        if (accept) begin
          state_d   = DS_ERR1;
          err_start = 1'b1;
        end
      end
      DS_ERR1: begin
        dft_ready = 1'b0;
        dft_resp  = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        dft_resp = HRESP_ERROR;
        if (accept) begin
          state_d   = DS_ERR1;
          err_start = 1'b1;
        end else if (HREADYS) begin
          state_d = DS_IDLE;
        end
      end
      default: state_d = DS_IDLE;
    endcase
  end

  // Error status update; clear wins over a same-cycle increment.
  always_comb begin
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    if (err_start) begin
      err_count_d = sat_inc(err_count_q);
      err_addr_d  = decode_addr_dec;
    end
    if (err_clr) begin
      err_count_d = '0;
    end
  end

  // State and status registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= DS_IDLE;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: rtl/ahb_decoder_stage_param.sv
// AHB decoder stage: maps the address phase onto one of NUM_PORTS output stages
// or the default slave, and returns the data-phase response from the port
// that owns the data phase.
module ahb_decoder_stage_param
  import ahb_decoder_pkg::*;
#(
  parameter int                            NUM_PORTS   = 4,
  parameter logic [NUM_PORTS*ADDR_W-1:0]   REGION_BASE = {NUM_PORTS{22'h0}},
  parameter logic [NUM_PORTS*ADDR_W-1:0]   REGION_MASK = {NUM_PORTS{22'h3FFFFF}},
  parameter int                            ERR_CNT_W   = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HREADYS,
  input  logic                    sel_dec,
  input  logic [ADDR_W-1:0]       decode_addr_dec,
  input  logic [1:0]              trans_dec,
  input  logic [NUM_PORTS-1:0]    port_en,
  input  logic [NUM_PORTS-1:0]    active_port,
  input  logic [NUM_PORTS-1:0]    readyout_port,
  input  logic [2*NUM_PORTS-1:0]  resp_port,
  input  logic [32*NUM_PORTS-1:0] rdata_port,
  output logic [NUM_PORTS-1:0]    sel_port,
  output logic                    active_dec,
  output logic                    HREADYOUTS,
  output logic [1:0]              HRESPS,
  output logic [31:0]             HRDATAS,
  output logic [ERR_CNT_W-1:0]    err_count,
  output logic [ADDR_W-1:0]       err_addr,
  input  logic                    err_clr
);

  localparam int             PW      = $clog2(NUM_PORTS + 1);
  localparam logic [PW-1:0]  DFT_IDX = PW'(NUM_PORTS);

  logic [PW-1:0] dec_port;
  logic [PW-1:0] addr_out_port;
  logic [PW-1:0] data_out_port_q, data_out_port_d;
  logic          data_port_live;
  logic          dft_sel;
  logic          dft_ready;
  logic [1:0]    dft_resp;

  // Region decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    dec_port = DFT_IDX;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_en[i] &&
          ((decode_addr_dec & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
           (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W]))) begin
        dec_port = PW'(i);
      end
    end
  end

  // On IDLE, stay on the data-phase port (if still a live port) to avoid needless switching.
  always_comb begin
    data_port_live = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if ((data_out_port_q == PW'(i)) && port_en[i]) begin
        data_port_live = 1'b1;
      end
    end
    addr_out_port = ((trans_dec == HTRANS_IDLE) && data_port_live) ? data_out_port_q : dec_port;
  end

  // One-hot selects and active flag of the address-phase target; default slave reads as active.
  always_comb begin
    sel_port   = '0;
    active_dec = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_out_port == PW'(i)) begin
        sel_port[i] = sel_dec;
        active_dec  = active_port[i];
      end
    end
    dft_sel = sel_dec & (addr_out_port == DFT_IDX);
  end

  // Data-phase owner advances only when the current transfer completes.
  always_comb begin
    data_out_port_d = HREADYS ? addr_out_port : data_out_port_q;
  end

  // Data-phase owner register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_out_port_q <= '0;
    end else begin
      data_out_port_q <= data_out_port_d;
    end
  end

  // Data-phase return mux; the default slave supplies zero read data.
  always_comb begin
    HREADYOUTS = dft_ready;
    HRESPS     = dft_resp;
    HRDATAS    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_out_port_q == PW'(i)) begin
        HREADYOUTS = readyout_port[i];
        HRESPS     = resp_port[i*2 +: 2];
        HRDATAS    = rdata_port[i*32 +: 32];
      end
    end
  end

  ahb_default_slave_err #(
    .ERR_CNT_W (ERR_CNT_W)
  ) u_dft (
    .HCLK            (HCLK),
    .HRESETn         (HRESETn),
    .HREADYS         (HREADYS),
    .dft_sel         (dft_sel),
    .xfer_active     (trans_dec[1]),
    .decode_addr_dec (decode_addr_dec),
    .err_clr         (err_clr),
    .dft_ready       (dft_ready),
    .dft_resp        (dft_resp),
    .err_count       (err_count),
    .err_addr        (err_addr)
  );

endmodule
